// File: rtl/maze_pkg.sv
// Shared maze geometry and the probe FSM / probe index types used by the
// mover, renderer and wall-probe responder.
package maze_pkg;

  localparam int MAZE_PIX_W   = 404;
  localparam int MAZE_PIX_H   = 447;
  localparam int TILE_SHIFT   = 3;
  localparam int MAZE_W_TILES = 51;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ISSUE,
    WAIT,
    DONE
  } probe_state_t;

  typedef enum logic [1:0] {
    TL = 2'd0,
    TR = 2'd1,
    BL = 2'd2,
    BR = 2'd3
  } probe_idx_t;

endpackage

// File: rtl/maze_probe_addr.sv
// Combinational probe-pixel to ROM-address mapping for one selected diagonal
// probe, with the per-axis out-of-range flags for that probe.
module maze_probe_addr #(
  parameter int MAZE_PIX_W   = maze_pkg::MAZE_PIX_W,
  parameter int MAZE_PIX_H   = maze_pkg::MAZE_PIX_H,
  parameter int TILE_SHIFT   = maze_pkg::TILE_SHIFT,
  parameter int MAZE_W_TILES = maze_pkg::MAZE_W_TILES,
  parameter int ADDR_W       = 12
) (
  input  logic [9:0]           ball_x,
  input  logic [9:0]           ball_y,
  input  logic [9:0]           ball_s,
  input  maze_pkg::probe_idx_t idx,
  output logic [ADDR_W-1:0]    addr,
  output logic                 x_oob,
  output logic                 y_oob
);
  import maze_pkg::*;

  logic [10:0] s1, xl, xr, yt, yb, px, py;
  logic        oxl, oxr, oyt, oyb;
  logic        is_left, is_top;

  assign s1 = {1'b0, ball_s} + 11'd1;
  assign xl = {1'b0, ball_x} - s1;
  assign xr = {1'b0, ball_x} + s1;
  assign yt = {1'b0, ball_y} - s1;
  assign yb = {1'b0, ball_y} + s1;

  // Left/top edges are checked before subtraction so underflow never aliases.
  assign oxl = {1'b0, ball_x} < s1;
  assign oxr = xr >= 11'(MAZE_PIX_W);
  assign oyt = {1'b0, ball_y} < s1;
  assign oyb = yb >= 11'(MAZE_PIX_H);

  assign is_left = (idx == TL) || (idx == BL);
  assign is_top  = (idx == TL) || (idx == TR);

  assign px    = is_left ? xl : xr;
  assign py    = is_top  ? yt : yb;
  assign x_oob = is_left ? oxl : oxr;
  assign y_oob = is_top  ? oyt : oyb;

  assign addr = ADDR_W'(32'(py >> TILE_SHIFT) * 32'(MAZE_W_TILES) + 32'(px >> TILE_SHIFT));

endmodule

// File: rtl/maze_probe.sv
// Per-frame wall probe: reads the maze ROM at the four diagonal corners just
// outside the sprite box and publishes them together as mapTL/TR/BL/BR.
module maze_probe #(
  parameter int MAZE_PIX_W   = maze_pkg::MAZE_PIX_W,
  parameter int MAZE_PIX_H   = maze_pkg::MAZE_PIX_H,
  parameter int TILE_SHIFT   = maze_pkg::TILE_SHIFT,
  parameter int MAZE_W_TILES = maze_pkg::MAZE_W_TILES,
  parameter int ROM_LAT      = 1,
  parameter int ADDR_W       = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [9:0]        BallX,
  input  logic [9:0]        BallY,
  input  logic [9:0]        BallS,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic              rom_data,
  output logic              mapTL,
  output logic              mapTR,
  output logic              mapBL,
  output logic              mapBR,
  output logic              probe_valid,
  output logic              busy
);
  import maze_pkg::*;

  localparam logic [2:0] LAST_TICK = 3'(3 + ROM_LAT);

  probe_state_t      state_q, state_d;
  logic [2:0]        tick_q, tick_d;
  logic              frame_clk_q;
  logic              start;
  logic [9:0]        x_q, y_q, s_q;
  logic [3:0]        force_q, fval_q, res_q;
  logic [3:0]        map_q, map_d;
  logic [1:0]        issue_k, samp_k;
  logic              samp_en, samp_bit;
  logic [ADDR_W-1:0] probe_addr;
  logic              x_oob, y_oob;

  assign start   = frame_clk & ~frame_clk_q;
  assign issue_k = tick_q[1:0];
  assign samp_k  = 2'(tick_q - 3'(ROM_LAT));
  assign samp_en = ((state_q == ISSUE) || (state_q == WAIT)) && (tick_q >= 3'(ROM_LAT));
  // Out-of-range probes carry their forced value alongside the in-flight read.
  assign samp_bit = force_q[samp_k] ? fval_q[samp_k] : rom_data;

  maze_probe_addr #(
    .MAZE_PIX_W  (MAZE_PIX_W),
    .MAZE_PIX_H  (MAZE_PIX_H),
    .TILE_SHIFT  (TILE_SHIFT),
    .MAZE_W_TILES(MAZE_W_TILES),
    .ADDR_W      (ADDR_W)
  ) u_addr (
    .ball_x(x_q),
    .ball_y(y_q),
    .ball_s(s_q),
    .idx   (probe_idx_t'(issue_k)),
    .addr  (probe_addr),
    .x_oob (x_oob),
    .y_oob (y_oob)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      frame_clk_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      s_q         <= '0;
      force_q     <= '0;
      fval_q      <= '0;
      res_q       <= '0;
      map_q       <= 4'b1111;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      frame_clk_q <= frame_clk;
      map_q       <= map_d;
      if (state_q == CALC) begin
        x_q <= BallX;
        y_q <= BallY;
        s_q <= BallS;
      end
      if (state_q == ISSUE) begin
        force_q[issue_k] <= x_oob | y_oob;
        fval_q[issue_k]  <= y_oob;
      end
      if (samp_en) begin
        res_q[samp_k] <= samp_bit;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    map_d   = map_q;
    unique case (state_q)
      IDLE: if (start) state_d = CALC;
      CALC: begin
        state_d = ISSUE;
        tick_d  = '0;
      end
      ISSUE: begin
        tick_d = tick_q + 3'd1;
        if (tick_q == 3'd3) state_d = WAIT;
      end
      WAIT: begin
        tick_d = tick_q + 3'd1;
        if (tick_q == LAST_TICK) begin
          state_d = DONE;
          map_d   = {samp_bit, res_q[2:0]};
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rom_rd      = (state_q == ISSUE);
  assign rom_addr    = (rom_rd && !x_oob && !y_oob) ? probe_addr : '0;
  assign probe_valid = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign mapTL       = map_q[0];
  assign mapTR       = map_q[1];
  assign mapBL       = map_q[2];
  assign mapBR       = map_q[3];

endmodule

// File: tb/tb_maze_probe.sv
// Bench for maze_probe: two instances (ROM latency 1 and 3) against a
// geometric reference model of the probe corners and maze ROM.
module tb_maze_probe;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_clk;
  logic [9:0] ball_x, ball_y, ball_s;

  logic [11:0] addr1, addr3;
  logic        rd1, rd3, data1, data3;
  logic        tl1, tr1, bl1, br1, pv1, busy1;
  logic        tl3, tr3, bl3, br3, pv3, busy3;

  logic mem [0:4095];
  logic p1_q, a3_q, b3_q, c3_q;

  int total  = 0;
  int passes = 0;
  logic [3:0] prev1, prev3;

  always #5 clk = ~clk;

  maze_probe #(.ROM_LAT(1)) u1 (
    .Clk(clk), .Reset(rst), .frame_clk(frame_clk),
    .BallX(ball_x), .BallY(ball_y), .BallS(ball_s),
    .rom_addr(addr1), .rom_rd(rd1), .rom_data(data1),
    .mapTL(tl1), .mapTR(tr1), .mapBL(bl1), .mapBR(br1),
    .probe_valid(pv1), .busy(busy1)
  );

  maze_probe #(.ROM_LAT(3)) u3 (
    .Clk(clk), .Reset(rst), .frame_clk(frame_clk),
    .BallX(ball_x), .BallY(ball_y), .BallS(ball_s),
    .rom_addr(addr3), .rom_rd(rd3), .rom_data(data3),
    .mapTL(tl3), .mapTR(tr3), .mapBL(bl3), .mapBR(br3),
    .probe_valid(pv3), .busy(busy3)
  );

  // ROM models with 1- and 3-cycle read latency.
  always @(posedge clk) begin
    p1_q <= mem[addr1];
    a3_q <= mem[addr3];
    b3_q <= a3_q;
    c3_q <= b3_q;
  end
  assign data1 = p1_q;
  assign data3 = c3_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 4096; i++)
      mem[i] = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode);
  endtask

  // Corner k: 0=TL 1=TR 2=BL 3=BR, one pixel diagonally outside the box.
  function automatic int corner_x(int x, int s, int k);
    return (k == 0 || k == 2) ? x - s - 1 : x + s + 1;
  endfunction
  function automatic int corner_y(int y, int s, int k);
    return (k < 2) ? y - s - 1 : y + s + 1;
  endfunction
  function automatic bit in_maze(int px, int py);
    return px >= 0 && px < 404 && py >= 0 && py < 447;
  endfunction

  function automatic int exp_addr(int x, int y, int s, int k);
    int px = corner_x(x, s, k);
    int py = corner_y(y, s, k);
    if (!in_maze(px, py)) return 0;
    return ((py / 8) * 51 + px / 8) % 4096;
  endfunction

  function automatic logic [3:0] model(int x, int y, int s);
    logic [3:0] m;
    for (int k = 0; k < 4; k++) begin
      int px = corner_x(x, s, k);
      int py = corner_y(y, s, k);
      if (py < 0 || py >= 447)      m[k] = 1'b1;
      else if (px < 0 || px >= 404) m[k] = 1'b0;
      else                          m[k] = mem[exp_addr(x, y, s, k)];
    end
    return m;
  endfunction

  // mode 0: plain scan, 1: extra frame edge at C3, 2: reset pulse at C4.
  task automatic run_scan(input int x, input int y, input int s, input int mode);
    logic [3:0] newm;
    int last_rd;
    ball_x = 10'(x);
    ball_y = 10'(y);
    ball_s = 10'(s);
    frame_clk = 1'b1;
    newm = model(x, y, s);
    last_rd = (mode == 2) ? 4 : 5;
    for (int c = 1; c <= 12; c++) begin
      logic [3:0] e1, e3;
      int ea;
      step();
      frame_clk = (mode == 1 && c == 3);
      rst = (mode == 2 && c == 4);
      ea = (c >= 2 && c <= last_rd) ? exp_addr(x, y, s, c - 2) : 0;
      if (mode == 2) begin
        e1 = (c >= 5) ? 4'b1111 : prev1;
        e3 = (c >= 5) ? 4'b1111 : prev3;
      end else begin
        e1 = (c >= 7) ? newm : prev1;
        e3 = (c >= 9) ? newm : prev3;
      end
      chk($sformatf("pv1 c%0d", c), 32'(pv1), 32'(mode != 2 && c == 7));
      chk($sformatf("pv3 c%0d", c), 32'(pv3), 32'(mode != 2 && c == 9));
      chk($sformatf("rd1 c%0d", c), 32'(rd1), 32'(c >= 2 && c <= last_rd));
      chk($sformatf("rd3 c%0d", c), 32'(rd3), 32'(c >= 2 && c <= last_rd));
      chk($sformatf("addr1 c%0d", c), 32'(addr1), 32'(ea));
      chk($sformatf("addr3 c%0d", c), 32'(addr3), 32'(ea));
      chk($sformatf("busy1 c%0d", c), 32'(busy1), 32'(c <= ((mode == 2) ? 4 : 7)));
      chk($sformatf("busy3 c%0d", c), 32'(busy3), 32'(c <= ((mode == 2) ? 4 : 9)));
      chk($sformatf("map1 c%0d", c), 32'({br1, bl1, tr1, tl1}), 32'(e1));
      chk($sformatf("map3 c%0d", c), 32'({br3, bl3, tr3, tl3}), 32'(e3));
    end
    rst = 1'b0;
    frame_clk = 1'b0;
    prev1 = (mode == 2) ? 4'b1111 : newm;
    prev3 = prev1;
    $display("scan x=%0d y=%0d s=%0d mode=%0d exp_map=%b map1=%b map3=%b",
             x, y, s, mode, newm, {br1, bl1, tr1, tl1}, {br3, bl3, tr3, tl3});
    step();
  endtask

  initial begin
    rst = 1'b1;
    frame_clk = 1'b0;
    ball_x = '0;
    ball_y = '0;
    ball_s = '0;
    fill(0);
    prev1 = 4'b1111;
    prev3 = 4'b1111;
    repeat (3) step();
    rst = 1'b0;
    step();
    step();
    chk("rst map1", 32'({br1, bl1, tr1, tl1}), 32'hF);
    chk("rst map3", 32'({br3, bl3, tr3, tl3}), 32'hF);
    chk("rst pv1", 32'(pv1), 0);
    chk("rst busy1", 32'(busy1), 0);
    chk("rst rd1", 32'(rd1), 0);
    chk("rst rd3", 32'(rd3), 0);

    chk("ref addr TL", 32'(exp_addr(202, 253, 13, 0)), 1502);
    chk("ref addr BR", 32'(exp_addr(202, 253, 13, 3)), 1710);

    fill(0);
    run_scan(202, 253, 13, 0);
    mem[1506] = 1'b1;
    run_scan(202, 253, 13, 0);
    chk("single wall map1", 32'({br1, bl1, tr1, tl1}), 32'b0010);
    chk("single wall map3", 32'({br3, bl3, tr3, tl3}), 32'b0010);
    fill(1);
    run_scan(10, 209, 13, 0);
    chk("left tunnel map1", 32'({br1, bl1, tr1, tl1}), 32'b1010);
    fill(0);
    run_scan(202, 10, 13, 0);
    chk("top wall map1", 32'({br1, bl1, tr1, tl1}), 32'b0011);
    fill(2);
    run_scan(202, 253, 13, 1);
    run_scan(150, 300, 20, 2);
    chk("post reset map1", 32'({br1, bl1, tr1, tl1}), 32'hF);
    run_scan(150, 300, 20, 0);

    for (int n = 0; n < 16; n++) begin
      fill(2);
      run_scan(int'($urandom_range(0, 430)), int'($urandom_range(0, 470)),
               int'($urandom_range(0, 40)), 0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
